instruction_controller: RTL and testbench
=========================================

Name: instruction_controller

Overview:
- Execution-side counterpart of the instruction ROM/PC unit: consumes the 10-bit instruction word ({op[3:0], arg1[2:0], arg2[2:0]}).
- Executes it against an internal six-entry register file and a single-cycle ALU.
- Returns the `done` / `branch` / `branchaddress` handshake that advances or redirects the fetch unit's PC.
- Keeps a shadow PC so that BL can form a return address.

Parameters:
- OP_SIZE, 4, opcode field width.
- ARG_SIZE, 3, operand (register select) field width.
- ARG_NUM, 2, operand fields per instruction.
- DATA_W, 8, register/ALU data width.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- run  input  1  1 = execute instructions; 0 = halt at the next instruction boundary.
- instruction  input  OP_SIZE+ARG_NUM*ARG_SIZE  current word from the fetch unit (rom[pc]), combinational on that side.
- data_in  input  DATA_W  external operand for LOAD.
- done  output  1  one-cycle pulse: instruction retired, fetch unit does pc+1.
- branch  output  1  one-cycle pulse: fetch unit loads branchaddress.
- branchaddress  output  4  branch target, valid while branch=1, else 0.
- bus_out  output  DATA_W  last value written to any register.
- carry  output  1  carry-out of the most recent ADD.
- busy  output  1  high in any state other than IDLE.

Behaviour:
Reset (rst=0, async):
- state=IDLE; R1..R6=0; IR=0; shadow pc=0.
- done=0, branch=0, branchaddress=0, bus_out=0, carry=0, busy=0.
- Reset mid-instruction abandons it with no register write and no pulse.

Register selects:
- 000=NA: reads 0; writes discarded.
- 001..110 = R1..R6.
- 111=PC: reads the zero-extended shadow pc; as a destination see MOVE.

FSM, 3 cycles per instruction:
- IDLE: if run=1, go to FETCH.
- FETCH: IR <= instruction; go to EXEC.
- EXEC: compute the result from IR and latch it in a result register.
  - LOAD samples data_in in this cycle.
  - Go to WB.
- WB: perform the write and drive exactly one of done/branch high for this cycle only. Then FETCH if run=1, else IDLE.
- The pulse coincides with the fetch unit's PC edge, so in the following FETCH `instruction` already reflects the new pc.

Opcodes (in WB unless stated):
- 0000 LOAD Rx: Rx <= data_in; done.
- 0001 MOVE Rx,Ry: Rx <= Ry; done.
  - If Rx=PC: no register write; branch=1 with branchaddress=Ry[3:0] instead of done.
- 0010 ADD Rx,Ry: {carry,Rx} <= Rx+Ry, (DATA_W+1)-bit sum, result wraps mod 2^DATA_W; done.
- 0011 XOR Rx,Ry: Rx <= Rx^Ry; done.
- 1000 BR Rx: branch=1, branchaddress=Rx[3:0]; no register write.
- 1001 BL Rx: R6 <= zero-extended (pc+1) mod 16; branch=1, branchaddress=Rx[3:0].
  - Target is read before the R6 write, so BL R6 jumps to the old R6.
- Any other opcode: NOP; done only.

Output and flag rules:
- bus_out updates on every register write, including writes to NA (shows the value that would have been written).
- carry changes only on ADD.

Shadow pc:
- +1 mod 16 on done (15 wraps to 0).
- Loaded with branchaddress on branch.
- Always equals the fetch unit's pc.

Boundary conditions:
- done and branch are never high together.
- run deasserted mid-instruction: the instruction completes, then the FSM enters IDLE.
- run low at reset release: stays in IDLE.
- Source equals destination (e.g. ADD R1,R1): operands are read before the write.

Test Plan:
- Program LOAD R1 / MOVE R2,R1 / ADD R1,R2 / XOR R1,R2, data_in=8'h05, run=1 from reset release → done high on cycles 3, 6, 9, 12.
  - Final R1=8'h0F, R2=8'h05, bus_out=8'h0F, carry=0.
  - branch never asserted.
- R1=8'hF0, R2=8'h20, ADD R1,R2 → R1=8'h10, carry=1, done for one cycle.
- R3=8'h0B, BL R3 at pc=4 → branch=1 with branchaddress=4'hB for one cycle, done=0, R6=8'h05, next fetch from pc 11.
- MOVE PC,R2 with R2=8'h13 → branch=1, branchaddress=4'h3, no register changes; LOAD NA with data_in=8'hAA → bus_out=8'hAA, R1..R6 unchanged, done pulses.
- run dropped during EXEC → done pulses in WB, then busy=0 and no further FETCH; rst=0 during EXEC → immediate IDLE, no done, all registers 0.
- Opcode 4'b0111 at pc=15 → done only; shadow pc wraps to 0.

Source files
------------

// File: rtl/instruction_controller.sv
// Execution unit for the 10-bit {op, arg1, arg2} instruction stream: a three-cycle FETCH/EXEC/WB
// sequencer over a six-entry register file, with done/branch handshakes back to the fetch unit.
module instruction_controller #(
   parameter int OP_SIZE  = 4,
   parameter int ARG_SIZE = 3,
   parameter int ARG_NUM  = 2,
   parameter int DATA_W   = 8
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 run,
   input  logic [OP_SIZE+ARG_NUM*ARG_SIZE-1:0]  instruction,
   input  logic [DATA_W-1:0]                    data_in,
   output logic                                 done,
   output logic                                 branch,
   output logic [3:0]                           branchaddress,
   output logic [DATA_W-1:0]                    bus_out,
   output logic                                 carry,
   output logic                                 busy
);

   localparam int IW = OP_SIZE + ARG_NUM * ARG_SIZE;

   localparam logic [OP_SIZE-1:0] OP_LOAD = OP_SIZE'(4'b0000);
   localparam logic [OP_SIZE-1:0] OP_MOVE = OP_SIZE'(4'b0001);
   localparam logic [OP_SIZE-1:0] OP_ADD  = OP_SIZE'(4'b0010);
   localparam logic [OP_SIZE-1:0] OP_XOR  = OP_SIZE'(4'b0011);
   localparam logic [OP_SIZE-1:0] OP_BR   = OP_SIZE'(4'b1000);
   localparam logic [OP_SIZE-1:0] OP_BL   = OP_SIZE'(4'b1001);

   localparam logic [ARG_SIZE-1:0] SEL_NA = '0;
   localparam logic [ARG_SIZE-1:0] SEL_R1 = ARG_SIZE'(1);
   localparam logic [ARG_SIZE-1:0] SEL_R6 = ARG_SIZE'(6);
   localparam logic [ARG_SIZE-1:0] SEL_PC = '1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_EXEC,
      S_WB
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [IW-1:0]         r_ir;
   logic [3:0]            r_pc;
   logic [DATA_W-1:0]     r_rf [1:6];
   logic [DATA_W-1:0]     r_bus;
   logic                  r_carry;

   // Values computed in EXEC and consumed in WB
   logic [DATA_W-1:0]     r_res;
   logic                  r_cout;
   logic                  r_add;
   logic                  r_wen;
   logic [ARG_SIZE-1:0]   r_wsel;
   logic                  r_br;
   logic [3:0]            r_tgt;

   logic [OP_SIZE-1:0]    w_op;
   logic [ARG_SIZE-1:0]   w_a1;
   logic [ARG_SIZE-1:0]   w_a2;
   logic [DATA_W-1:0]     w_view [0:7];
   logic [DATA_W-1:0]     w_va;
   logic [DATA_W-1:0]     w_vb;
   logic [3:0]            w_pc_inc;
   logic [DATA_W:0]       w_sum;
   logic [DATA_W-1:0]     w_res;
   logic                  w_cout;
   logic                  w_add;
   logic                  w_wen;
   logic [ARG_SIZE-1:0]   w_wsel;
   logic                  w_br;
   logic [3:0]            w_tgt;
   logic                  w_wb;

   assign w_op     = r_ir[IW-1 -: OP_SIZE];
   assign w_a1     = r_ir[2*ARG_SIZE-1 -: ARG_SIZE];
   assign w_a2     = r_ir[ARG_SIZE-1:0];
   assign w_pc_inc = r_pc + 4'd1;

   // Select 0 reads as zero, 7 reads the shadow pc, the rest are R1..R6
   always_comb begin
      w_view[0] = '0;
      for (int i = 1; i <= 6; i++) begin
         w_view[i] = r_rf[i];
      end
      w_view[7] = {{(DATA_W-4){1'b0}}, r_pc};
   end

   assign w_va  = w_view[w_a1];
   assign w_vb  = w_view[w_a2];
   assign w_sum = {1'b0, w_va} + {1'b0, w_vb};

   always_comb begin
      w_res  = '0;
      w_cout = 1'b0;
      w_add  = 1'b0;
      w_wen  = 1'b0;
      w_wsel = w_a1;
      w_br   = 1'b0;
      w_tgt  = '0;
      case (w_op)
         OP_LOAD: begin
            w_res = data_in;
            w_wen = 1'b1;
         end
         OP_MOVE: begin
            if (w_a1 == SEL_PC) begin
               w_br  = 1'b1;
               w_tgt = w_vb[3:0];
            end else begin
               w_res = w_vb;
               w_wen = 1'b1;
            end
         end
         OP_ADD: begin
            {w_cout, w_res} = w_sum;
            w_add = 1'b1;
            w_wen = 1'b1;
         end
         OP_XOR: begin
            w_res = w_va ^ w_vb;
            w_wen = 1'b1;
         end
         OP_BR: begin
            w_br  = 1'b1;
            w_tgt = w_va[3:0];
         end
         OP_BL: begin
            // Target comes from the pre-write register view, so BL R6 uses the old R6
            w_br   = 1'b1;
            w_tgt  = w_va[3:0];
            w_res  = {{(DATA_W-4){1'b0}}, w_pc_inc};
            w_wsel = SEL_R6;
            w_wen  = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (run) w_next = S_FETCH;
         S_FETCH: w_next = S_EXEC;
         S_EXEC:  w_next = S_WB;
         S_WB:    w_next = run ? S_FETCH : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_ir   <= '0;
         r_res  <= '0;
         r_cout <= 1'b0;
         r_add  <= 1'b0;
         r_wen  <= 1'b0;
         r_wsel <= SEL_NA;
         r_br   <= 1'b0;
         r_tgt  <= '0;
      end else begin
         if (r_state == S_FETCH) begin
            r_ir <= instruction;
         end
         if (r_state == S_EXEC) begin
            r_res  <= w_res;
            r_cout <= w_cout;
            r_add  <= w_add;
            r_wen  <= w_wen;
            r_wsel <= w_wsel;
            r_br   <= w_br;
            r_tgt  <= w_tgt;
         end
      end
   end

   assign w_wb = (r_state == S_WB);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 1; i <= 6; i++) begin
            r_rf[i] <= '0;
         end
         r_bus   <= '0;
         r_carry <= 1'b0;
         r_pc    <= '0;
      end else if (w_wb) begin
         // Writes to NA or PC are dropped but still show on the bus
         if (r_wen) begin
            if (r_wsel >= SEL_R1 && r_wsel <= SEL_R6) begin
               r_rf[r_wsel] <= r_res;
            end
            r_bus <= r_res;
         end
         if (r_add) begin
            r_carry <= r_cout;
         end
         r_pc <= r_br ? r_tgt : w_pc_inc;
      end
   end

   assign done          = w_wb && !r_br;
   assign branch        = w_wb && r_br;
   assign branchaddress = branch ? r_tgt : 4'd0;
   assign bus_out       = r_bus;
   assign carry         = r_carry;
   assign busy          = (r_state != S_IDLE);

endmodule

// File: tb/tb_instruction_controller.sv
// Directed bench for instruction_controller: a small ROM plus fetch-unit pc that follows
// done/branch, with hand-computed expectations for each program.
module tb_instruction_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        run = 1'b0;
   logic [9:0]  instruction;
   logic [7:0]  data_in = 8'h00;
   logic        done;
   logic        branch;
   logic [3:0]  branchaddress;
   logic [7:0]  bus_out;
   logic        carry;
   logic        busy;

   logic [9:0]  rom [0:15];
   logic [3:0]  pc;
   int          n_checks = 0;
   int          n_fail   = 0;

   logic        p_d;
   logic        p_b;
   logic [3:0]  p_a;
   logic        p_after;
   logic [11:0] obs_done;
   logic        obs_any;

   localparam logic [9:0] NOP = 10'b0111_000_000;

   instruction_controller #(
      .OP_SIZE  (4),
      .ARG_SIZE (3),
      .ARG_NUM  (2),
      .DATA_W   (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .run           (run),
      .instruction   (instruction),
      .data_in       (data_in),
      .done          (done),
      .branch        (branch),
      .branchaddress (branchaddress),
      .bus_out       (bus_out),
      .carry         (carry),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst)        pc <= 4'd0;
      else if (branch) pc <= branchaddress;
      else if (done)   pc <= pc + 4'd1;
   end

   assign instruction = rom[pc];

   function automatic logic [9:0] enc(input logic [3:0] op, input logic [2:0] a, input logic [2:0] b);
      return {op, a, b};
   endfunction

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
      end
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 16; i++) rom[i] = NOP;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      run = 1'b0;
      #1;
      check("reset_outputs", {busy, done, branch, branchaddress, bus_out, carry}, '0);
      repeat (2) @(negedge clk);
   endtask

   task automatic pulse();
      logic got;
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         @(negedge clk);
         if (done || branch) begin
            got   = 1'b1;
            p_d   = done;
            p_b   = branch;
            p_a   = branchaddress;
         end
      end
      if (!got) begin
         check("pulse_timeout", got, 1);
         p_d = 1'b0;
         p_b = 1'b0;
         p_a = 4'd0;
      end
      @(negedge clk);
      p_after = done | branch;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // LOAD R1 / MOVE R2,R1 / ADD R1,R2 / XOR R1,R2, then read R1 and R2 back
      clear_rom();
      rom[0] = enc(4'b0000, 3'd1, 3'd0);
      rom[1] = enc(4'b0001, 3'd2, 3'd1);
      rom[2] = enc(4'b0010, 3'd1, 3'd2);
      rom[3] = enc(4'b0011, 3'd1, 3'd2);
      rom[4] = enc(4'b0001, 3'd0, 3'd1);
      rom[5] = enc(4'b0001, 3'd0, 3'd2);
      do_reset();
      data_in = 8'h05;
      rst = 1'b1;
      run = 1'b1;
      obs_done = '0;
      obs_any  = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         obs_done[c] = done;
         obs_any     = obs_any | branch;
      end
      check("t1_done_cycles", obs_done, 12'h924);
      check("t1_no_branch", obs_any, 1'b0);
      @(negedge clk);
      check("t1_bus_final", bus_out, 8'h0F);
      check("t1_carry", carry, 1'b0);
      pulse();
      check("t1_r1", bus_out, 8'h0F);
      pulse();
      check("t1_r2", bus_out, 8'h05);

      // ADD with carry-out: F0 + 20 = 1_10
      clear_rom();
      rom[0] = enc(4'b0000, 3'd1, 3'd0);
      rom[1] = enc(4'b0000, 3'd2, 3'd0);
      rom[2] = enc(4'b0010, 3'd1, 3'd2);
      rom[3] = enc(4'b0001, 3'd0, 3'd2);
      rom[4] = enc(4'b0001, 3'd0, 3'd1);
      do_reset();
      data_in = 8'hF0;
      rst = 1'b1;
      run = 1'b1;
      pulse();
      data_in = 8'h20;
      pulse();
      pulse();
      check("t2_add_pulse", {p_d, p_b, p_after}, 3'b100);
      check("t2_carry", carry, 1'b1);
      check("t2_sum", bus_out, 8'h10);
      pulse();
      check("t2_r2", bus_out, 8'h20);
      check("t2_carry_held", carry, 1'b1);
      pulse();
      check("t2_r1", bus_out, 8'h10);

      // BL R3 at pc 4 -> jump to 11, R6 = 5
      clear_rom();
      rom[0]  = enc(4'b0000, 3'd3, 3'd0);
      rom[4]  = enc(4'b1001, 3'd3, 3'd0);
      rom[5]  = enc(4'b0000, 3'd2, 3'd0);
      rom[11] = enc(4'b0000, 3'd0, 3'd0);
      rom[12] = enc(4'b0001, 3'd0, 3'd6);
      do_reset();
      data_in = 8'h0B;
      rst = 1'b1;
      run = 1'b1;
      pulse();
      data_in = 8'h3C;
      repeat (3) pulse();
      pulse();
      check("t3_bl_pulse", {p_d, p_b, p_after}, 3'b010);
      check("t3_bl_target", p_a, 4'hB);
      check("t3_bl_link", bus_out, 8'h05);
      pulse();
      check("t3_fetch_from_11", bus_out, 8'h3C);
      pulse();
      check("t3_r6", bus_out, 8'h05);

      // MOVE PC,R2 with R2 = 13 -> jump to 3; LOAD NA shows AA only on the bus
      clear_rom();
      rom[0] = enc(4'b0000, 3'd2, 3'd0);
      rom[1] = enc(4'b0001, 3'd7, 3'd2);
      rom[2] = enc(4'b0000, 3'd1, 3'd0);
      rom[3] = enc(4'b0000, 3'd0, 3'd0);
      rom[4] = enc(4'b0001, 3'd0, 3'd2);
      rom[5] = enc(4'b0001, 3'd0, 3'd1);
      do_reset();
      data_in = 8'h13;
      rst = 1'b1;
      run = 1'b1;
      pulse();
      data_in = 8'hAA;
      pulse();
      check("t4_move_pc_pulse", {p_d, p_b, p_a}, {1'b0, 1'b1, 4'h3});
      check("t4_move_pc_nowrite", bus_out, 8'h13);
      pulse();
      check("t4_load_na_done", {p_d, p_b}, 2'b10);
      check("t4_load_na_bus", bus_out, 8'hAA);
      pulse();
      check("t4_r2_kept", bus_out, 8'h13);
      pulse();
      check("t4_r1_kept", bus_out, 8'h00);

      // run dropped during EXEC, then reset during EXEC
      clear_rom();
      rom[0] = enc(4'b0000, 3'd1, 3'd0);
      rom[1] = enc(4'b0000, 3'd2, 3'd0);
      do_reset();
      data_in = 8'h77;
      rst = 1'b1;
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      run = 1'b0;
      @(negedge clk);
      check("t5_done_in_wb", done, 1'b1);
      @(negedge clk);
      check("t5_idle_after_wb", busy, 1'b0);
      obs_any = 1'b0;
      repeat (5) begin
         @(negedge clk);
         obs_any = obs_any | busy | done | branch;
      end
      check("t5_stays_idle", obs_any, 1'b0);
      check("t5_load_bus", bus_out, 8'h77);
      data_in = 8'h55;
      run = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("t5_async_reset", {busy, done, branch, bus_out}, '0);
      @(negedge clk);
      rst = 1'b1;
      run = 1'b0;
      obs_any = 1'b0;
      repeat (4) begin
         @(negedge clk);
         obs_any = obs_any | busy | done;
      end
      check("t5_run_low_release", obs_any, 1'b0);
      rom[0] = enc(4'b0001, 3'd0, 3'd1);
      run = 1'b1;
      pulse();
      check("t5_r1_cleared", bus_out, 8'h00);

      // NOP opcode 0111 at pc 15 wraps the shadow pc to 0
      clear_rom();
      rom[0]  = enc(4'b0000, 3'd1, 3'd0);
      rom[1]  = enc(4'b1000, 3'd1, 3'd0);
      rom[15] = enc(4'b0111, 3'd0, 3'd0);
      do_reset();
      data_in = 8'h0F;
      rst = 1'b1;
      run = 1'b1;
      pulse();
      rom[0] = enc(4'b0001, 3'd0, 3'd7);
      pulse();
      check("t6_br_pulse", {p_d, p_b, p_a}, {1'b0, 1'b1, 4'hF});
      pulse();
      check("t6_nop_pulse", {p_d, p_b, p_after}, 3'b100);
      pulse();
      check("t6_pc_wrapped", bus_out, 8'h00);

      run = 1'b0;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
